// File: rtl/char_pixel_fetch.sv
// Text-mode pixel pipeline: raster (x,y) -> screen buffer -> glyph ROM -> one mono pixel, 5 clocks.
// No backpressure; advances every clock, sync/de delayed to match the pixel.
module char_pixel_fetch #(
   parameter int COLS         = 80,
   parameter int ROWS         = 24,
   parameter int ADDR_W       = 11,
   parameter int BLINK_FRAMES = 30
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              font_8x8,
   input  logic [9:0]        vid_x,
   input  logic [9:0]        vid_y,
   input  logic              vid_de,
   input  logic              vid_hs,
   input  logic              vid_vs,
   output logic [ADDR_W-1:0] buf_addr,
   input  logic [7:0]        buf_data,
   output logic [11:0]       rom_addr,
   input  logic [7:0]        rom_data,
   input  logic [6:0]        cursor_x,
   input  logic [4:0]        cursor_y,
   input  logic              cursor_en,
   output logic              pix_out,
   output logic              de_out,
   output logic              hs_out,
   output logic              vs_out
);

   localparam int BW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

   logic [6:0]        col;
   logic [6:0]        trow;
   logic [3:0]        grow;
   logic              in_range;
   logic              hit;
   logic [ADDR_W-1:0] lin;

   // Index 0 is the stage after the first edge; the highest index feeds the output stage.
   logic [2:0] bit_d [4];
   logic [3:0] rng_d, hit_d, de_d, hs_d, vs_d;
   logic [1:0] font_d;
   logic [3:0] grow_d [2];
   logic [1:0] inv_d;

   logic          vs_prev;
   logic [BW-1:0] blink_cnt;
   logic          blink_phase;

   always_comb begin
      col      = vid_x[9:3];
      trow     = font_8x8 ? vid_y[9:3] : {1'b0, vid_y[9:4]};
      grow     = font_8x8 ? {1'b0, vid_y[2:0]} : vid_y[3:0];
      in_range = vid_de && (int'(col) < COLS) && (int'(trow) < ROWS);
      // An out-of-range cursor can only match an out-of-range cell, which is blanked anyway.
      hit      = (col == cursor_x) && (trow == {2'b00, cursor_y});
      lin      = ADDR_W'(trow) * ADDR_W'(COLS) + ADDR_W'(col);
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         buf_addr  <= '0;
         rom_addr  <= '0;
         pix_out   <= 1'b0;
         de_out    <= 1'b0;
         hs_out    <= 1'b0;
         vs_out    <= 1'b0;
         bit_d[0]  <= '0;
         bit_d[1]  <= '0;
         bit_d[2]  <= '0;
         bit_d[3]  <= '0;
         rng_d     <= '0;
         hit_d     <= '0;
         de_d      <= '0;
         hs_d      <= '0;
         vs_d      <= '0;
         font_d    <= '0;
         grow_d[0] <= '0;
         grow_d[1] <= '0;
         inv_d     <= '0;
      end else begin
         buf_addr  <= in_range ? lin : '0;
         bit_d[0]  <= vid_x[2:0];
         bit_d[1]  <= bit_d[0];
         bit_d[2]  <= bit_d[1];
         bit_d[3]  <= bit_d[2];
         rng_d     <= {rng_d[2:0], in_range};
         hit_d     <= {hit_d[2:0], hit};
         de_d      <= {de_d[2:0], vid_de};
         hs_d      <= {hs_d[2:0], vid_hs};
         vs_d      <= {vs_d[2:0], vid_vs};
         font_d    <= {font_d[0], font_8x8};
         grow_d[0] <= grow;
         grow_d[1] <= grow_d[0];

         // buf_data belongs to the pixel now in the second sideband stage.
         rom_addr  <= font_d[1] ? {2'b00, buf_data[6:0], grow_d[1][2:0]}
                                : {buf_data, grow_d[1]};
         inv_d     <= {inv_d[0], font_d[1] & buf_data[7]};

         pix_out   <= rng_d[3] & (rom_data[3'd7 - bit_d[3]] ^ inv_d[1]
                                  ^ (hit_d[3] & blink_phase & cursor_en));
         de_out    <= de_d[3];
         hs_out    <= hs_d[3];
         vs_out    <= vs_d[3];
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         vs_prev     <= 1'b0;
         blink_cnt   <= '0;
         blink_phase <= 1'b1;
      end else begin
         vs_prev <= vid_vs;
         if (vid_vs && !vs_prev) begin
            if (blink_cnt == BW'(BLINK_FRAMES - 1)) begin
               blink_cnt   <= '0;
               blink_phase <= ~blink_phase;
            end else begin
               blink_cnt <= blink_cnt + 1'b1;
            end
         end
      end
   end

endmodule

// File: tb/tb_char_pixel_fetch.sv
// Directed bench for char_pixel_fetch with behavioural screen RAM and glyph ROM.
module tb_char_pixel_fetch;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        font_8x8 = 1'b1;
   logic [9:0]  vid_x = '0, vid_y = '0;
   logic        vid_de = 1'b0, vid_hs = 1'b0, vid_vs = 1'b0;
   logic [10:0] buf_addr;
   logic [7:0]  buf_data = '0;
   logic [11:0] rom_addr;
   logic [7:0]  rom_data = '0;
   logic [6:0]  cursor_x = '0;
   logic [4:0]  cursor_y = '0;
   logic        cursor_en = 1'b0;
   logic        pix_out, de_out, hs_out, vs_out;

   logic [7:0] ram [0:2047];
   logic [7:0] rom [0:4095];

   int checks = 0;
   int errors = 0;

   char_pixel_fetch #(.COLS(80), .ROWS(24), .ADDR_W(11), .BLINK_FRAMES(30)) dut (
      .clk(clk), .reset(reset), .font_8x8(font_8x8),
      .vid_x(vid_x), .vid_y(vid_y), .vid_de(vid_de), .vid_hs(vid_hs), .vid_vs(vid_vs),
      .buf_addr(buf_addr), .buf_data(buf_data), .rom_addr(rom_addr), .rom_data(rom_data),
      .cursor_x(cursor_x), .cursor_y(cursor_y), .cursor_en(cursor_en),
      .pix_out(pix_out), .de_out(de_out), .hs_out(hs_out), .vs_out(vs_out)
   );

   always #5 clk = ~clk;

   always @(posedge clk) begin
      buf_data <= ram[buf_addr];
      rom_data <= rom[rom_addr];
   end

   typedef struct {
      logic        font;
      logic [9:0]  x;
      logic [9:0]  y;
      logic        de;
      logic [7:0]  code;
      logic [7:0]  rom_val;
      logic [10:0] ba;
      logic [11:0] ra;
      logic        chk_ra;
      logic        pix;
      logic        de_o;
   } vec_t;

   vec_t vt [12];

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      vid_de = 1'b0; vid_x = '0; vid_y = '0; vid_hs = 1'b0; vid_vs = 1'b0;
   endtask

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   // One isolated pixel: capture buf_addr at t+1, rom_addr at t+3, pix/de at t+5.
   task automatic run_pix(input logic f, input logic [9:0] x, input logic [9:0] y, input logic de,
                          output logic [10:0] ba, output logic [11:0] ra,
                          output logic p, output logic d);
      font_8x8 = f; vid_x = x; vid_y = y; vid_de = de;
      step();
      ba = buf_addr;
      idle();
      step();
      step();
      ra = rom_addr;
      step();
      step();
      p = pix_out;
      d = de_out;
   endtask

   task automatic vs_pulse(input int n);
      for (int i = 0; i < n; i++) begin
         vid_vs = 1'b1; step();
         vid_vs = 1'b0; step();
      end
   endtask

   logic [10:0] ba;
   logic [11:0] ra;
   logic        p, d;
   logic [7:0]  pat;

   initial begin
      for (int i = 0; i < 2048; i++) ram[i] = 8'h00;
      for (int i = 0; i < 4096; i++) rom[i] = 8'h00;

      //            font  x    y    de  code   rom    ba    ra     chk pix de_o
      vt[0]  = '{1'b1, 10'd0,   10'd3,   1'b1, 8'h41, 8'h3C, 11'd0,    12'h20B, 1'b1, 1'b0, 1'b1};
      vt[1]  = '{1'b1, 10'd2,   10'd3,   1'b1, 8'h41, 8'h3C, 11'd0,    12'h20B, 1'b1, 1'b1, 1'b1};
      vt[2]  = '{1'b1, 10'd7,   10'd3,   1'b1, 8'h41, 8'h3C, 11'd0,    12'h20B, 1'b1, 1'b0, 1'b1};
      vt[3]  = '{1'b1, 10'd0,   10'd3,   1'b1, 8'hC1, 8'h3C, 11'd0,    12'h20B, 1'b1, 1'b1, 1'b1};
      vt[4]  = '{1'b1, 10'd2,   10'd3,   1'b1, 8'hC1, 8'h3C, 11'd0,    12'h20B, 1'b1, 1'b0, 1'b1};
      vt[5]  = '{1'b0, 10'd632, 10'd377, 1'b1, 8'hC4, 8'h80, 11'd1919, 12'hC49, 1'b1, 1'b1, 1'b1};
      vt[6]  = '{1'b0, 10'd639, 10'd377, 1'b1, 8'hC4, 8'h80, 11'd1919, 12'hC49, 1'b1, 1'b0, 1'b1};
      vt[7]  = '{1'b1, 10'd100, 10'd50,  1'b1, 8'h5A, 8'h08, 11'd492,  12'h2D2, 1'b1, 1'b1, 1'b1};
      vt[8]  = '{1'b0, 10'd9,   10'd20,  1'b1, 8'h85, 8'h40, 11'd81,   12'h854, 1'b1, 1'b1, 1'b1};
      vt[9]  = '{1'b1, 10'd0,   10'd200, 1'b1, 8'h41, 8'hFF, 11'd0,    12'h208, 1'b0, 1'b0, 1'b1};
      vt[10] = '{1'b1, 10'd640, 10'd0,   1'b1, 8'h41, 8'hFF, 11'd0,    12'h208, 1'b0, 1'b0, 1'b1};
      vt[11] = '{1'b1, 10'd0,   10'd3,   1'b0, 8'h41, 8'hFF, 11'd0,    12'h20B, 1'b0, 1'b0, 1'b0};

      // Reset state with active-looking inputs applied.
      vid_de = 1'b1; vid_hs = 1'b1; vid_vs = 1'b1; vid_x = 10'd8;
      step(); step(); step();
      chk("rst_pix", 32'(pix_out), 32'd0);
      chk("rst_de", 32'(de_out), 32'd0);
      chk("rst_hs", 32'(hs_out), 32'd0);
      chk("rst_vs", 32'(vs_out), 32'd0);
      chk("rst_buf_addr", 32'(buf_addr), 32'd0);
      chk("rst_rom_addr", 32'(rom_addr), 32'd0);
      idle();
      reset = 1'b0;
      step(); step(); step(); step(); step(); step();

      for (int i = 0; i < 12; i++) begin
         ram[vt[i].ba] = vt[i].code;
         rom[vt[i].ra] = vt[i].rom_val;
         run_pix(vt[i].font, vt[i].x, vt[i].y, vt[i].de, ba, ra, p, d);
         chk($sformatf("v%0d_buf_addr", i), 32'(ba), 32'(vt[i].ba));
         if (vt[i].chk_ra) chk($sformatf("v%0d_rom_addr", i), 32'(ra), 32'(vt[i].ra));
         chk($sformatf("v%0d_pix", i), 32'(p), 32'(vt[i].pix));
         chk($sformatf("v%0d_de", i), 32'(d), 32'(vt[i].de_o));
      end

      // Back-to-back pixels x=0..7, hs on pixel 3 and vs on pixel 5 must stay aligned.
      ram[0] = 8'h41;
      rom[12'h20B] = 8'h3C;
      pat = 8'b00111100;
      for (int c = 0; c < 14; c++) begin
         if (c < 8) begin
            font_8x8 = 1'b1; vid_x = 10'(c); vid_y = 10'd3; vid_de = 1'b1;
            vid_hs = (c == 3); vid_vs = (c == 5);
         end else begin
            idle();
         end
         step();
         if (c == 3) chk("stream_de_before", 32'(de_out), 32'd0);
         if (c >= 4 && c < 12) begin
            chk($sformatf("stream_pix%0d", c - 4), 32'(pix_out), 32'(pat[7 - (c - 4)]));
            chk($sformatf("stream_de%0d", c - 4), 32'(de_out), 32'd1);
            chk($sformatf("stream_hs%0d", c - 4), 32'(hs_out), 32'((c - 4) == 3));
            chk($sformatf("stream_vs%0d", c - 4), 32'(vs_out), 32'((c - 4) == 5));
         end
      end

      // Asynchronous reset with pixels in flight.
      for (int c = 0; c < 5; c++) begin
         font_8x8 = 1'b1; vid_x = 10'(2 + (c % 4)); vid_y = 10'd3; vid_de = 1'b1; vid_hs = 1'b1;
         step();
      end
      chk("pre_rst_pix", 32'(pix_out), 32'd1);
      chk("pre_rst_hs", 32'(hs_out), 32'd1);
      #2;
      reset = 1'b1;
      #1;
      chk("async_rst_pix", 32'(pix_out), 32'd0);
      chk("async_rst_de", 32'(de_out), 32'd0);
      chk("async_rst_hs", 32'(hs_out), 32'd0);
      chk("async_rst_buf_addr", 32'(buf_addr), 32'd0);
      chk("async_rst_rom_addr", 32'(rom_addr), 32'd0);
      idle();
      step();
      reset = 1'b0;
      font_8x8 = 1'b1; vid_x = 10'd2; vid_y = 10'd3; vid_de = 1'b1;
      step();
      idle();
      step(); step(); step();
      chk("post_rst_de_t4", 32'(de_out), 32'd0);
      chk("post_rst_pix_t4", 32'(pix_out), 32'd0);
      step();
      chk("post_rst_de_t5", 32'(de_out), 32'd1);
      chk("post_rst_pix_t5", 32'(pix_out), 32'd1);

      // Block cursor at (2,1); blank glyphs everywhere.
      ram[81] = 8'h00; ram[82] = 8'h00; ram[83] = 8'h00;
      rom[12'h002] = 8'h00;
      cursor_x = 7'd2; cursor_y = 5'd1; cursor_en = 1'b1;
      run_pix(1'b1, 10'd20, 10'd10, 1'b1, ba, ra, p, d);
      chk("cur_hit_buf_addr", 32'(ba), 32'd82);
      chk("cur_hit_pix", 32'(p), 32'd1);
      run_pix(1'b1, 10'd16, 10'd15, 1'b1, ba, ra, p, d);
      chk("cur_corner_pix", 32'(p), 32'd1);
      run_pix(1'b1, 10'd24, 10'd10, 1'b1, ba, ra, p, d);
      chk("cur_right_pix", 32'(p), 32'd0);
      run_pix(1'b1, 10'd15, 10'd10, 1'b1, ba, ra, p, d);
      chk("cur_left_pix", 32'(p), 32'd0);
      cursor_en = 1'b0;
      run_pix(1'b1, 10'd20, 10'd10, 1'b1, ba, ra, p, d);
      chk("cur_disabled_pix", 32'(p), 32'd0);
      cursor_en = 1'b1;

      vs_pulse(29);
      run_pix(1'b1, 10'd20, 10'd10, 1'b1, ba, ra, p, d);
      chk("blink_29_pix", 32'(p), 32'd1);
      vs_pulse(1);
      run_pix(1'b1, 10'd20, 10'd10, 1'b1, ba, ra, p, d);
      chk("blink_30_pix", 32'(p), 32'd0);
      vs_pulse(29);
      run_pix(1'b1, 10'd20, 10'd10, 1'b1, ba, ra, p, d);
      chk("blink_59_pix", 32'(p), 32'd0);
      vs_pulse(1);
      run_pix(1'b1, 10'd20, 10'd10, 1'b1, ba, ra, p, d);
      chk("blink_60_pix", 32'(p), 32'd1);

      // Cursor outside the screen must never light a cell.
      cursor_x = 7'd100; cursor_y = 5'd1;
      run_pix(1'b1, 10'd20, 10'd10, 1'b1, ba, ra, p, d);
      chk("cur_oob_pix", 32'(p), 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/char_pixel_fetch.md
Name: char_pixel_fetch

Overview:
- Text-mode pixel pipeline between the video timing generator and the DVI/VGA output stage.
- Per pixel clock, it converts the raster position (x,y) into a screen-buffer address, then forms the `char_rom` address from the fetched code and glyph row.
- It selects the glyph bit, applies inverse video and the blinking block cursor, and emits one monochrome pixel.
- Sync and data-enable are delayed to stay aligned with the pixel.
- One pixel per clock; fixed latency.

Parameters:
- COLS, 80, text columns per row.
- ROWS, 24, text rows per screen.
- ADDR_W, 11, screen-buffer address width (must satisfy COLS*ROWS <= 2^ADDR_W).
- BLINK_FRAMES, 30, frames per cursor blink half-period.

Ports:
- clk  in  1  pixel clock
- reset  in  1  asynchronous, active-high reset
- font_8x8  in  1  1 = 8x8 font, 7-bit codes; 0 = 8x16 font, 8-bit codes
- vid_x  in  10  raster column, valid when vid_de=1
- vid_y  in  10  raster line, valid when vid_de=1
- vid_de  in  1  active-video enable
- vid_hs  in  1  horizontal sync, passed through
- vid_vs  in  1  vertical sync, passed through, active-high
- buf_addr  out  ADDR_W  screen-buffer read address
- buf_data  in  8  character code; synchronous RAM, valid 1 clk after buf_addr
- rom_addr  out  12  glyph ROM address
- rom_data  in  8  glyph row, MSB = leftmost pixel, valid 1 clk after rom_addr
- cursor_x  in  7  cursor column
- cursor_y  in  5  cursor row
- cursor_en  in  1  cursor visible
- pix_out  out  1  pixel, 1 = foreground
- de_out  out  1  delayed vid_de
- hs_out  out  1  delayed vid_hs
- vs_out  out  1  delayed vid_vs

Behaviour:
- Reset (asynchronous, active-high):
  - All pipeline registers, buf_addr, rom_addr, pix_out, de_out, hs_out and vs_out go to 0.
  - Blink frame counter goes to 0; blink_phase goes to 1 (cursor visible).
- Stage 0 (inputs at cycle t):
  - col = vid_x[9:3]; bit index = vid_x[2:0].
  - 8x8 mode: glyph row = vid_y[2:0], text row = vid_y[9:3].
  - 8x16 mode: glyph row = vid_y[3:0], text row = vid_y[9:4].
- Range check: in_range = vid_de & (col < COLS) & (text row < ROWS).
- buf_addr is registered at t+1:
  - in range: text_row*COLS + col, truncated to ADDR_W (constant multiply);
  - otherwise: 0.
- buf_data is sampled at t+2, then rom_addr is registered at t+3:
  - 8x8 mode: {2'b00, code[6:0], row[2:0]}; inverse flag = code[7].
  - 8x16 mode: {code[7:0], row[3:0]}; inverse flag = 0.
- rom_data is sampled at t+4. pix_out is registered at t+5:
  - pix_out = rom_data[7 - bitidx] ^ inverse ^ (cursor_hit & blink_phase & cursor_en).
  - pix_out is forced to 0 when in_range = 0.
- Cursor hit: cursor_hit = (col == cursor_x) & (text row == cursor_y), computed in stage 0. It inverts the full cell as a block cursor.
- Delay alignment: bitidx, in_range, cursor_hit, font mode and inverse travel through delay registers matched to their stage.
- Total latency from inputs to pix_out/de_out/hs_out/vs_out = 5 clocks, identical for all four outputs.
- font_8x8 is sampled in stage 0 and carried with the pixel. A change mid-line affects only pixels entered after the change; there is no pipeline flush.
- Blink:
  - Counter increments on each vid_vs rising edge (registered edge detect).
  - On reaching BLINK_FRAMES-1 the counter wraps to 0 and blink_phase toggles.
  - The counter runs regardless of cursor_en.
- Out-of-range cursor (cursor_x >= COLS or cursor_y >= ROWS): never hits, no effect.
- No backpressure: the pipeline advances every clock. vid_de=0 cycles still propagate; their pix_out = 0.

Test Plan:
- Reset asserted mid-frame with pixels in flight -> all outputs 0 immediately, without waiting for a clock edge. After release, first valid pixel appears 5 clocks after the first input.
- 8x8 mode, cell (0,0) = 0x41, y=3, x=0..7 consecutive, rom_data = 8'b00111100 -> buf_addr = 0 at t+1, rom_addr = 0x20B at t+3, pix_out = 0,0,1,1,1,1,0,0 at t+5..t+12, de_out aligned.
- Same pixels with code 0xC1 -> rom_addr still 0x20B; pix_out = 1,1,0,0,0,0,1,1.
- 8x16 mode, x=632, y=377 (col 79, row 23, glyph row 9), code 0xC4 -> buf_addr = 1919, rom_addr = 0xC49, no inversion.
- Cursor (2,1) enabled, 8x8 mode, y=8..15, x=16..23, rom_data = 0 -> pix_out = 1 for that cell only.
  - After 30 vid_vs rising edges -> pix_out = 0.
  - After 30 more -> pix_out = 1 again.
- 8x8 mode, y=200 (text row 25) or x=640 (col 80) with vid_de=1 -> pix_out = 0, buf_addr = 0, de_out = 1 after 5 clocks.
